// File: rtl/pipe_control.sv
// Main control for a 5-stage MIPS pipeline: ID decode, load-use/freeze stalls, BEQ resolve
// and ID/EX, EX/MEM, MEM/WB control registers. Define PIPE_CONTROL_BNE_EN to also decode BNE.
module pipe_control #(
  parameter int REG_AW = 5,
  parameter int OPC_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              branch_equal,
  input  logic              dmem_ready,
  output logic              stall,
  output logic              if_flush,
  output logic              branch_taken,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic [REG_AW-1:0] ex_dst,
  output logic              mem_read,
  output logic              mem_write,
  output logic [REG_AW-1:0] mem_dst,
  output logic              wb_reg_write,
  output logic              wb_memto_reg,
  output logic [REG_AW-1:0] wb_dst
);

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
`ifdef PIPE_CONTROL_BNE_EN
  localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(6'b000101);
`endif

  typedef struct packed {
    logic [1:0]        alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              memto_reg;
    logic [REG_AW-1:0] dst;
  } ex_ctrl_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              memto_reg;
    logic [REG_AW-1:0] dst;
  } mem_ctrl_t;

  typedef struct packed {
    logic              reg_write;
    logic              memto_reg;
    logic [REG_AW-1:0] dst;
  } wb_ctrl_t;

  ex_ctrl_t  w_dec;
  logic      w_use_rs, w_use_rt, w_is_br, w_br_cond;
  logic      w_freeze, w_load_use;
  ex_ctrl_t  r_idex;
  mem_ctrl_t r_exmem;
  wb_ctrl_t  r_memwb;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_dec     = '0;
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_is_br   = 1'b0;
    w_br_cond = 1'b0;
    if (id_valid) begin
      case (id_opcode)
        OP_LW: begin
          w_dec.alu_src   = 1'b1;
          w_dec.mem_read  = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.memto_reg = 1'b1;
          w_dec.dst       = id_rt;
          w_use_rs        = 1'b1;
        end
        OP_SW: begin
          w_dec.alu_src   = 1'b1;
          w_dec.mem_write = 1'b1;
          w_use_rs        = 1'b1;
          w_use_rt        = 1'b1;
        end
        OP_ADDI: begin
          w_dec.alu_op    = 2'b11;
          w_dec.alu_src   = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.dst       = id_rt;
          w_use_rs        = 1'b1;
        end
        OP_BEQ: begin
          w_dec.alu_op = 2'b01;
          w_use_rs     = 1'b1;
          w_use_rt     = 1'b1;
          w_is_br      = 1'b1;
          w_br_cond    = branch_equal;
        end
`ifdef PIPE_CONTROL_BNE_EN
        OP_BNE: begin
          w_dec.alu_op = 2'b01;
          w_use_rs     = 1'b1;
          w_use_rt     = 1'b1;
          w_is_br      = 1'b1;
          w_br_cond    = ~branch_equal;
        end
`endif
        OP_RTYPE: begin
          w_dec.alu_op    = 2'b10;
          w_dec.reg_write = 1'b1;
          w_dec.dst       = id_rd;
          w_use_rs        = 1'b1;
          w_use_rt        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A freeze masks load-use: the hazard is re-evaluated once memory completes.
  assign w_freeze   = (r_exmem.mem_read | r_exmem.mem_write) & ~dmem_ready;
  assign w_load_use = ~w_freeze & r_idex.mem_read & (r_idex.dst != '0) &
                      ((w_use_rs & (r_idex.dst == id_rs)) | (w_use_rt & (r_idex.dst == id_rt)));

  assign stall        = ~reset & (w_freeze | w_load_use);
  assign branch_taken = ~reset & ~stall & w_is_br & w_br_cond;
  assign if_flush     = branch_taken;

  // NOTE: pipeline state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else if (w_freeze) begin
      // ID/EX and EX/MEM hold; a bubble stops write-back from repeating.
      r_memwb <= '0;
    end else begin
      r_idex  <= w_load_use ? '0 : w_dec;
      r_exmem <= '{mem_read:  r_idex.mem_read,  mem_write: r_idex.mem_write,
                   reg_write: r_idex.reg_write, memto_reg: r_idex.memto_reg,
                   dst:       r_idex.dst};
      r_memwb <= '{reg_write: r_exmem.reg_write, memto_reg: r_exmem.memto_reg,
                   dst:       r_exmem.dst};
    end
  end

  assign ex_alu_op    = r_idex.alu_op;
  assign ex_alu_src   = r_idex.alu_src;
  assign ex_dst       = r_idex.dst;
  assign mem_read     = r_exmem.mem_read;
  assign mem_write    = r_exmem.mem_write;
  assign mem_dst      = r_exmem.dst;
  assign wb_reg_write = r_memwb.reg_write;
  assign wb_memto_reg = r_memwb.memto_reg;
  assign wb_dst       = r_memwb.dst;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: decode, latency, load-use, branch, freeze and reset cases.
module tb_pipe_control;

  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       branch_equal, dmem_ready;
  logic       stall, if_flush, branch_taken;
  logic [1:0] ex_alu_op;
  logic       ex_alu_src;
  logic [4:0] ex_dst;
  logic       mem_read, mem_write;
  logic [4:0] mem_dst;
  logic       wb_reg_write, wb_memto_reg;
  logic [4:0] wb_dst;

  int total = 0;
  int bad   = 0;
  logic bne_exp;

  pipe_control #(.REG_AW(5), .OPC_W(6)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .branch_equal(branch_equal),
    .dmem_ready(dmem_ready), .stall(stall), .if_flush(if_flush),
    .branch_taken(branch_taken), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_dst(ex_dst), .mem_read(mem_read), .mem_write(mem_write), .mem_dst(mem_dst),
    .wb_reg_write(wb_reg_write), .wb_memto_reg(wb_memto_reg), .wb_dst(wb_dst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"},  32'(stall), 0);
    check({tag, ".flush"},  32'(if_flush), 0);
    check({tag, ".taken"},  32'(branch_taken), 0);
    check({tag, ".aluop"},  32'(ex_alu_op), 0);
    check({tag, ".alusrc"}, 32'(ex_alu_src), 0);
    check({tag, ".exdst"},  32'(ex_dst), 0);
    check({tag, ".mrd"},    32'(mem_read), 0);
    check({tag, ".mwr"},    32'(mem_write), 0);
    check({tag, ".mdst"},   32'(mem_dst), 0);
    check({tag, ".wbwe"},   32'(wb_reg_write), 0);
    check({tag, ".wbm2r"},  32'(wb_memto_reg), 0);
    check({tag, ".wbdst"},  32'(wb_dst), 0);
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic be);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; branch_equal = be;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef PIPE_CONTROL_BNE_EN
    bne_exp = 1'b1;
`else
    bne_exp = 1'b0;
`endif
    reset = 1'b1; dmem_ready = 1'b1;
    // A taken BEQ presented during reset must still leave every output at 0.
    set_id(1, OP_BEQ, 1, 1, 0, 1);
    check_all_zero("in_reset");
    set_id(0, OP_RT, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check_all_zero("idle");
      tick();
    end

    // R-type then ADDI: latency of EX, MEM and WB fields
    set_id(1, OP_RT, 1, 2, 3, 0);
    check("rt.stall", 32'(stall), 0);
    tick();
    set_id(1, OP_ADDI, 1, 4, 7, 0);
    check("rt.exdst", 32'(ex_dst), 3);
    check("rt.aluop", 32'(ex_alu_op), 2);
    check("rt.alusrc", 32'(ex_alu_src), 0);
    tick();
    set_id(0, OP_RT, 0, 0, 0, 0);
    check("addi.aluop", 32'(ex_alu_op), 3);
    check("addi.alusrc", 32'(ex_alu_src), 1);
    check("addi.exdst", 32'(ex_dst), 4);
    check("rt.mdst", 32'(mem_dst), 3);
    tick();
    check("rt.wbdst", 32'(wb_dst), 3);
    check("rt.wbwe", 32'(wb_reg_write), 1);
    check("rt.wbm2r", 32'(wb_memto_reg), 0);
    check("addi.mdst", 32'(mem_dst), 4);
    tick();
    check("addi.wbdst", 32'(wb_dst), 4);

    // LW rt=5 then R-type rs=5: one-cycle load-use bubble
    set_id(1, OP_LW, 1, 5, 0, 0);
    check("lw.stall", 32'(stall), 0);
    tick();
    set_id(1, OP_RT, 5, 6, 7, 0);
    check("lu.stall", 32'(stall), 1);
    check("lu.flush", 32'(if_flush), 0);
    check("lw.exdst", 32'(ex_dst), 5);
    check("lw.aluop", 32'(ex_alu_op), 0);
    check("lw.alusrc", 32'(ex_alu_src), 1);
    tick();
    check("lu.stall_rel", 32'(stall), 0);
    check("lu.bub_exdst", 32'(ex_dst), 0);
    check("lu.bub_aluop", 32'(ex_alu_op), 0);
    check("lw.mrd", 32'(mem_read), 1);
    check("lw.mdst", 32'(mem_dst), 5);
    tick();
    check("lu.cons_exdst", 32'(ex_dst), 7);
    check("lu.cons_aluop", 32'(ex_alu_op), 2);
    check("lu.bub_mrd", 32'(mem_read), 0);
    check("lw.wbwe", 32'(wb_reg_write), 1);
    check("lw.wbm2r", 32'(wb_memto_reg), 1);
    check("lw.wbdst", 32'(wb_dst), 5);

    // LW to r0 never triggers a hazard
    set_id(1, OP_LW, 1, 0, 0, 0);
    tick();
    set_id(1, OP_RT, 0, 6, 7, 0);
    check("lw0.stall", 32'(stall), 0);
    tick();
    check("lw0.cons_exdst", 32'(ex_dst), 7);
    // ADDI does not read rt; SW does
    set_id(1, OP_LW, 1, 8, 0, 0);
    tick();
    set_id(1, OP_ADDI, 1, 8, 0, 0);
    check("addi_rt.stall", 32'(stall), 0);
    tick();
    set_id(1, OP_LW, 1, 8, 0, 0);
    tick();
    set_id(1, OP_SW, 1, 8, 0, 0);
    check("sw_rt.stall", 32'(stall), 1);
    tick();
    set_id(0, OP_RT, 0, 0, 0, 0);
    tick();

    // BEQ taken / not taken
    set_id(1, OP_BEQ, 2, 3, 0, 1);
    check("beq.flush", 32'(if_flush), 1);
    check("beq.taken", 32'(branch_taken), 1);
    check("beq.stall", 32'(stall), 0);
    tick();
    set_id(0, OP_RT, 0, 0, 0, 0);
    check("beq.flush_1cyc", 32'(if_flush), 0);
    check("beq.aluop", 32'(ex_alu_op), 1);
    check("beq.exdst", 32'(ex_dst), 0);
    set_id(1, OP_BEQ, 2, 3, 0, 0);
    check("beq_ne.taken", 32'(branch_taken), 0);
    tick();
    // BEQ depending on a load: stall first, resolve next cycle
    set_id(1, OP_LW, 1, 2, 0, 0);
    tick();
    set_id(1, OP_BEQ, 2, 3, 0, 1);
    check("beqlu.stall", 32'(stall), 1);
    check("beqlu.flush", 32'(if_flush), 0);
    check("beqlu.taken", 32'(branch_taken), 0);
    tick();
    check("beqlu.stall2", 32'(stall), 0);
    check("beqlu.flush2", 32'(if_flush), 1);
    check("beqlu.taken2", 32'(branch_taken), 1);
    set_id(0, OP_RT, 0, 0, 0, 0);
    tick(); tick(); tick();

    // Memory freeze: LW in MEM with dmem_ready low for 3 cycles, SW behind it
    set_id(1, OP_LW, 1, 9, 0, 0);
    tick();
    set_id(1, OP_SW, 1, 11, 0, 0);
    check("frz.pre_stall", 32'(stall), 0);
    tick();
    dmem_ready = 1'b0;
    set_id(0, OP_RT, 0, 0, 0, 0);
    check("frz1.stall", 32'(stall), 1);
    check("frz1.mrd", 32'(mem_read), 1);
    check("frz1.mdst", 32'(mem_dst), 9);
    check("frz1.alusrc", 32'(ex_alu_src), 1);
    check("frz1.wbwe", 32'(wb_reg_write), 0);
    tick();
    set_id(1, OP_BEQ, 4, 4, 0, 1);
    check("frz2.stall", 32'(stall), 1);
    check("frz2.flush", 32'(if_flush), 0);
    check("frz2.taken", 32'(branch_taken), 0);
    check("frz2.mdst", 32'(mem_dst), 9);
    check("frz2.wbwe", 32'(wb_reg_write), 0);
    tick();
    set_id(0, OP_RT, 0, 0, 0, 0);
    check("frz3.stall", 32'(stall), 1);
    check("frz3.mrd", 32'(mem_read), 1);
    check("frz3.wbwe", 32'(wb_reg_write), 0);
    tick();
    dmem_ready = 1'b1;
    #1;
    check("frz_rel.stall", 32'(stall), 0);
    check("frz_rel.wbwe", 32'(wb_reg_write), 0);
    tick();
    check("frz_wb.wbwe", 32'(wb_reg_write), 1);
    check("frz_wb.wbm2r", 32'(wb_memto_reg), 1);
    check("frz_wb.wbdst", 32'(wb_dst), 9);
    check("frz_sw.mwr", 32'(mem_write), 1);
    check("frz_sw.mrd", 32'(mem_read), 0);
    tick();
    check("frz_once.wbwe", 32'(wb_reg_write), 0);
    check("frz_done.mwr", 32'(mem_write), 0);

    // BNE: taken on branch_equal=0 only when the option is built in
    set_id(1, OP_BNE, 1, 2, 0, 0);
    check("bne.flush", 32'(if_flush), 32'(bne_exp));
    check("bne.taken", 32'(branch_taken), 32'(bne_exp));
    tick();
    set_id(0, OP_RT, 0, 0, 0, 0);
    check("bne.aluop", 32'(ex_alu_op), bne_exp ? 32'd1 : 32'd0);
    tick();

    // Reset asserted mid-freeze abandons the access
    set_id(1, OP_LW, 1, 12, 0, 0);
    tick();
    set_id(0, OP_RT, 0, 0, 0, 0);
    tick();
    dmem_ready = 1'b0;
    #1 check("rstfrz.stall", 32'(stall), 1);
    reset = 1'b1;
    #1 check_all_zero("rst_mid_freeze");
    tick();
    reset = 1'b0;
    #1 check_all_zero("post_reset");
    dmem_ready = 1'b1;
    tick();
    check_all_zero("post_reset2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
